// File: rtl/ifu_sram_rsp_pkg.sv
// ----------------------------------------------------------------------------
// ifu_sram_rsp_pkg
// Shared encodings for the instruction-fetch SRAM read responder and the AXI4
// burst address generator:
//   - AXI4 burst encodings (FIXED / INCR / WRAP)
//   - AXI4 response encodings (OKAY / SLVERR)
//   - AXI4_RRESP_BUS / AXI4_RID_BUS bus widths
//   - responder FSM state encoding
//   - wrap_len_ok(): legal WRAP burst lengths (2, 4, 8 or 16 beats)
// ----------------------------------------------------------------------------
package ifu_sram_rsp_pkg;

    localparam int AXI4_RRESP_BUS = 2;
    localparam int AXI4_RID_BUS   = 4;

    localparam logic [1:0] AXI4_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI4_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // WRAP is only meaningful for 2, 4, 8 or 16 beats (arlen 1, 3, 7, 15).
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi4_burst_addr_gen
// Purely combinational AXI4 next-beat address calculator, shared by the read
// and write responders.
// Ports:
//   addr      in  ADDR_W  current beat byte address
//   size      in  3       log2 of bytes per beat
//   len       in  8       burst length minus 1
//   burst     in  2       burst type
//   next_addr out ADDR_W  address of the following beat
// FIXED keeps the address, INCR adds 1<<size (modulo 2^ADDR_W), WRAP with a
// legal length wraps inside the aligned (len+1)<<size block; WRAP with an
// illegal length and the reserved encoding both fall back to INCR.
// ----------------------------------------------------------------------------
module axi4_burst_addr_gen
    import ifu_sram_rsp_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ONE << size;
        incr_addr = addr + step;
        // Mask of the offset bits inside the wrap block.
        wrap_mask = ((ADDR_W'(len) + ONE) << size) - ONE;
        next_addr = incr_addr;
        case (burst)
            AXI4_BURST_FIXED: next_addr = addr;
            AXI4_BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/ifu_sram_rsp.sv
// ----------------------------------------------------------------------------
// ifu_sram_rsp
// AXI4 read-only responder between the IFU's AXI master port and a
// synchronous instruction SRAM. Accepts one AR request at a time, reads one
// SRAM word per beat and returns R beats with rid/rresp/rlast.
// Ports:
//   clock, reset           clock; asynchronous active-low reset
//   arvalid_i/arready_o    AR handshake; araddr_i, arid_i, arlen_i,
//                          arsize_i, arburst_i carry the request
//   rvalid_o/rready_i      R handshake; rdata_o, rresp_o, rlast_o, rid_o
//   mem_en_o, mem_addr_o   SRAM read strobe and byte address
//   mem_rdata_i            SRAM read data, valid the cycle after mem_en_o
// Optional build macro IFU_SRAM_RSP_ADDR_CHECK_EN: beats outside
// [MEM_BASE, MEM_BASE+MEM_SIZE), and every beat of a reserved-burst request,
// skip the SRAM read and return SLVERR with zero data.
// Every output is decoded from the state or from registers.
// ----------------------------------------------------------------------------
module ifu_sram_rsp
    import ifu_sram_rsp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                ID_W     = 4,
    parameter int                LATENCY  = 0,
    parameter logic [ADDR_W-1:0] MEM_BASE = 'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 'h0800_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    input  logic [ADDR_W-1:0]         araddr_i,
    input  logic [ID_W-1:0]           arid_i,
    input  logic [7:0]                arlen_i,
    input  logic [2:0]                arsize_i,
    input  logic [1:0]                arburst_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [AXI4_RRESP_BUS-1:0] rresp_o,
    output logic                      rlast_o,
    output logic [ID_W-1:0]           rid_o,
    output logic                      mem_en_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    generate
        if (DATA_W < 8 || DATA_W > 64 || (DATA_W & (DATA_W - 1)) != 0 ||
            ID_W != AXI4_RID_BUS || LATENCY < 0 || LATENCY > 255 ||
            (64'(MEM_BASE) + 64'(MEM_SIZE)) > (64'd1 << ADDR_W)) begin : g_param_error
            $error("ifu_sram_rsp: illegal parameter setting");
        end
    endgenerate

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0]         cur_addr;
    logic [ID_W-1:0]           id_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [7:0]                beat_cnt;
    logic [7:0]                dly_cnt;
    logic [DATA_W-1:0]         rdata_q;
    logic [AXI4_RRESP_BUS-1:0] rresp_q;

    logic [ADDR_W-1:0] next_addr;
    logic              last_beat;
    logic              beat_err;

    assign last_beat = (beat_cnt == len_q);

`ifdef IFU_SRAM_RSP_ADDR_CHECK_EN
    // Subtract-then-compare keeps the window test free of overflow at the
    // top of the address space.
    assign beat_err = (burst_q == 2'b11) || (cur_addr < MEM_BASE) ||
                      ((cur_addr - MEM_BASE) >= MEM_SIZE);
`else
    assign beat_err = 1'b0;
`endif

    axi4_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (cur_addr),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arvalid_i) begin
                    state_next = (LATENCY > 0) ? ST_DELAY : ST_FETCH;
                end
            end
            ST_DELAY: begin
                if (dly_cnt <= 8'd1) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RESP;
            ST_RESP: begin
                if (rready_i) begin
                    state_next = last_beat ? ST_IDLE : ST_FETCH;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- request / beat datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_addr <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            dly_cnt  <= '0;
            rdata_q  <= '0;
            rresp_q  <= AXI4_RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arvalid_i) begin
                        cur_addr <= araddr_i;
                        id_q     <= arid_i;
                        len_q    <= arlen_i;
                        size_q   <= arsize_i;
                        burst_q  <= arburst_i;
                        beat_cnt <= '0;
                        dly_cnt  <= 8'(LATENCY);
                    end
                end
                ST_DELAY: dly_cnt <= dly_cnt - 8'd1;
                ST_LOAD: begin
                    // cur_addr is unchanged since FETCH, so beat_err still
                    // describes the beat whose data arrives now.
                    rdata_q <= beat_err ? '0 : mem_rdata_i;
                    rresp_q <= beat_err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
                end
                ST_RESP: begin
                    if (rready_i && !last_beat) begin
                        cur_addr <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        arready_o  = 1'b0;
        rvalid_o   = 1'b0;
        rlast_o    = 1'b0;
        mem_en_o   = 1'b0;
        mem_addr_o = '0;
        case (state_reg)
            ST_IDLE:  arready_o = 1'b1;
            ST_FETCH: begin
                mem_en_o   = ~beat_err;
                mem_addr_o = cur_addr;
            end
            ST_RESP: begin
                rvalid_o = 1'b1;
                rlast_o  = last_beat;
            end
            default: ;
        endcase
    end

    assign rdata_o = rdata_q;
    assign rresp_o = rresp_q;
    assign rid_o   = id_q;

endmodule

// File: tb/tb_ifu_sram_rsp.sv
`timescale 1ns/1ps
module tb_ifu_sram_rsp;
    import ifu_sram_rsp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arvalid_lat, rready;

    logic        arready, rvalid, rlast, mem_en;
    logic [31:0] rdata, mem_addr, mem_rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;

    logic        arready_lat, rvalid_lat, rlast_lat, mem_en_lat;
    logic [31:0] rdata_lat, mem_addr_lat, mem_rdata_lat;
    logic [1:0]  rresp_lat;
    logic [3:0]  rid_lat;

    int checks = 0;
    int errors = 0;

    ifu_sram_rsp #(.LATENCY(0)) dut (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arid_i(arid),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .rlast_o(rlast), .rid_o(rid),
        .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    ifu_sram_rsp #(.LATENCY(4)) dut_lat (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid_lat), .arready_o(arready_lat), .araddr_i(araddr), .arid_i(arid),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid_lat), .rready_i(rready), .rdata_o(rdata_lat), .rresp_o(rresp_lat),
        .rlast_o(rlast_lat), .rid_o(rid_lat),
        .mem_en_o(mem_en_lat), .mem_addr_o(mem_addr_lat), .mem_rdata_i(mem_rdata_lat)
    );

    // Memory content is a fixed function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    always @(posedge clock) begin
        if (mem_en)     mem_rdata     <= mem_word(mem_addr);
        if (mem_en_lat) mem_rdata_lat <= mem_word(mem_addr_lat);
    end

    // Observations from the LATENCY=0 instance.
    logic [31:0] obs_maddr[$];
    logic [31:0] obs_rdata[$];
    logic        obs_rlast[$];
    logic [1:0]  obs_rresp[$];
    logic [3:0]  obs_rid[$];
    int          first_rv, first_men;
    bit          timed_out;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
    endtask

    // Records every mem_en cycle and every R handshake until rlast or budget.
    // Cycle index 0 is the sample point right after the AR handshake edge.
    task automatic collect(input int max_cycles);
        int n;
        bit done;
        obs_maddr.delete(); obs_rdata.delete(); obs_rlast.delete();
        obs_rresp.delete(); obs_rid.delete();
        first_rv = -1; first_men = -1; done = 1'b0; n = 0;
        rready = 1'b1;
        while (!done && n < max_cycles) begin
            if (mem_en) begin
                obs_maddr.push_back(mem_addr);
                if (first_men < 0) first_men = n;
            end
            if (rvalid) begin
                if (first_rv < 0) first_rv = n;
                obs_rdata.push_back(rdata);
                obs_rlast.push_back(rlast);
                obs_rresp.push_back(rresp);
                obs_rid.push_back(rid);
                if (rlast) done = 1'b1;
            end
            step();
            n++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({arready, rvalid, rlast, rresp, rid, mem_en} !== 10'b1_0_0_00_0000_0) begin
            errors++;
            $display("FAIL reset_ctrl: got arready=%b rvalid=%b rlast=%b rresp=%b rid=%h mem_en=%b, want 1 0 0 00 0 0",
                     arready, rvalid, rlast, rresp, rid, mem_en);
        end
        checks++;
        if ({rdata, mem_addr} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h mem_addr=%h, want 0 0", rdata, mem_addr);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({arready, rvalid, arready_lat, rvalid_lat} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_release: got arready=%b rvalid=%b arready_lat=%b rvalid_lat=%b, want 1 0 1 0",
                     arready, rvalid, arready_lat, rvalid_lat);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_single();
        issue_ar(32'h8000_0010, 4'd3, 8'd0, 3'd2, AXI4_BURST_INCR);
        collect(20);
        checks++;
        if (timed_out || obs_rdata.size() != 1 || obs_maddr.size() != 1) begin
            errors++;
            $display("FAIL single_count: got beats=%0d mem_reads=%0d timeout=%b, want 1 1 0",
                     obs_rdata.size(), obs_maddr.size(), timed_out);
        end
        checks++;
        if (obs_maddr[0] !== 32'h8000_0010 || first_men != 0) begin
            errors++;
            $display("FAIL single_mem: got addr=%h at cycle %0d, want 80000010 at 0", obs_maddr[0], first_men);
        end
        checks++;
        if (first_rv != 2) begin
            errors++;
            $display("FAIL single_latency: got rvalid at cycle %0d, want 2", first_rv);
        end
        checks++;
        if ({obs_rlast[0], obs_rid[0], obs_rresp[0], obs_rdata[0]} !== {1'b1, 4'd3, 2'b00, 32'hDA5A_5A4A}) begin
            errors++;
            $display("FAIL single_beat: got rlast=%b rid=%h rresp=%b rdata=%h, want 1 3 00 da5a5a4a",
                     obs_rlast[0], obs_rid[0], obs_rresp[0], obs_rdata[0]);
        end
        $display("single: addr=%h rdata=%h rlast=%b", obs_maddr[0], obs_rdata[0], obs_rlast[0]);
    endtask

    typedef struct packed {
        logic [31:0]      addr;
        logic [2:0]       size;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [0:3][31:0] exp;
    } scen_t;

    task automatic test_burst_modes();
        scen_t tbl[6];
        int nb;
        bit err;
        logic [31:0] ea, ed;
        tbl[0] = '{addr: 32'h8000_0000, size: 3'd2, len: 8'd3, burst: AXI4_BURST_INCR,
                   exp: '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C}};
        tbl[1] = '{addr: 32'h8000_0008, size: 3'd2, len: 8'd3, burst: AXI4_BURST_WRAP,
                   exp: '{32'h8000_0008, 32'h8000_000C, 32'h8000_0000, 32'h8000_0004}};
        tbl[2] = '{addr: 32'h8000_0020, size: 3'd2, len: 8'd2, burst: AXI4_BURST_FIXED,
                   exp: '{32'h8000_0020, 32'h8000_0020, 32'h8000_0020, 32'h0}};
        tbl[3] = '{addr: 32'h8000_0008, size: 3'd2, len: 8'd2, burst: AXI4_BURST_WRAP,
                   exp: '{32'h8000_0008, 32'h8000_000C, 32'h8000_0010, 32'h0}};
        tbl[4] = '{addr: 32'h8000_0040, size: 3'd2, len: 8'd1, burst: 2'b11,
                   exp: '{32'h8000_0040, 32'h8000_0044, 32'h0, 32'h0}};
        tbl[5] = '{addr: 32'h8000_0038, size: 3'd3, len: 8'd1, burst: AXI4_BURST_WRAP,
                   exp: '{32'h8000_0038, 32'h8000_0030, 32'h0, 32'h0}};
        for (int s = 0; s < 6; s++) begin
            nb = int'(tbl[s].len) + 1;
`ifdef IFU_SRAM_RSP_ADDR_CHECK_EN
            err = (tbl[s].burst == 2'b11);
`else
            err = 1'b0;
`endif
            issue_ar(tbl[s].addr, 4'(s + 1), tbl[s].len, tbl[s].size, tbl[s].burst);
            collect(40);
            checks++;
            if (timed_out || obs_rdata.size() != nb || obs_maddr.size() != (err ? 0 : nb)) begin
                errors++;
                $display("FAIL burst%0d_count: got beats=%0d mem_reads=%0d timeout=%b, want %0d %0d 0",
                         s, obs_rdata.size(), obs_maddr.size(), timed_out, nb, err ? 0 : nb);
            end
            for (int i = 0; i < nb; i++) begin
                ea = tbl[s].exp[i];
                ed = err ? 32'h0 : mem_word(ea);
                if (!err) begin
                    checks++;
                    if (obs_maddr[i] !== ea) begin
                        errors++;
                        $display("FAIL burst%0d_addr%0d: got %h want %h", s, i, obs_maddr[i], ea);
                    end
                end
                checks++;
                if ({obs_rdata[i], obs_rlast[i], obs_rid[i], obs_rresp[i]} !==
                    {ed, (i == nb - 1), 4'(s + 1), err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY}) begin
                    errors++;
                    $display("FAIL burst%0d_beat%0d: got rdata=%h rlast=%b rid=%h rresp=%b, want %h %b %h %b",
                             s, i, obs_rdata[i], obs_rlast[i], obs_rid[i], obs_rresp[i],
                             ed, (i == nb - 1), 4'(s + 1), err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY);
                end
            end
            $display("burst%0d: burst=%b len=%0d beats=%0d", s, tbl[s].burst, tbl[s].len, obs_rdata.size());
        end
    endtask

    task automatic test_len255();
        int lasts;
        issue_ar(32'h8000_0000, 4'd6, 8'd255, 3'd2, AXI4_BURST_INCR);
        collect(1000);
        lasts = 0;
        foreach (obs_rlast[i]) if (obs_rlast[i]) lasts++;
        checks++;
        if (timed_out || obs_rdata.size() != 256 || lasts != 1) begin
            errors++;
            $display("FAIL len255_count: got beats=%0d rlasts=%0d timeout=%b, want 256 1 0",
                     obs_rdata.size(), lasts, timed_out);
        end
        checks++;
        if (obs_maddr[255] !== 32'h8000_03FC || obs_rlast[255] !== 1'b1) begin
            errors++;
            $display("FAIL len255_last: got addr=%h rlast=%b, want 800003fc 1", obs_maddr[255], obs_rlast[255]);
        end
        $display("len255: beats=%0d last_addr=%h", obs_rdata.size(), obs_maddr[255]);
    endtask

    task automatic test_backpressure();
        int n;
        rready = 1'b0;
        issue_ar(32'h8000_0100, 4'd5, 8'd1, 3'd2, AXI4_BURST_INCR);
        n = 0;
        while (!rvalid && n < 10) begin step(); n++; end
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDA5A_5B5A || rlast !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got rvalid=%b rdata=%h rlast=%b, want 1 da5a5b5a 0", rvalid, rdata, rlast);
        end
        arid = 4'd9;
        arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({rvalid, rdata, rlast, rid, arready} !== {1'b1, 32'hDA5A_5B5A, 1'b0, 4'd5, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got rvalid=%b rdata=%h rlast=%b rid=%h arready=%b, want 1 da5a5b5a 0 5 0",
                         c, rvalid, rdata, rlast, rid, arready);
            end
        end
        arvalid = 1'b0;
        rready = 1'b1;
        step();
        collect(20);
        checks++;
        if (timed_out || obs_rdata.size() != 1 || obs_maddr[0] !== 32'h8000_0104 ||
            obs_rlast[0] !== 1'b1 || obs_rid[0] !== 4'd5) begin
            errors++;
            $display("FAIL bp_second: got beats=%0d addr=%h rlast=%b rid=%h, want 1 80000104 1 5",
                     obs_rdata.size(), obs_maddr[0], obs_rlast[0], obs_rid[0]);
        end
        $display("backpressure: held 5 cycles, second beat addr=%h", obs_maddr[0]);
    endtask

    task automatic test_back_to_back();
        int hs[$];
        araddr = 32'h8000_0200; arid = 4'd1; arlen = 8'd0; arsize = 3'd2; arburst = AXI4_BURST_INCR;
        rready = 1'b1;
        arvalid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (arvalid && arready) hs.push_back(n);
            step();
        end
        arvalid = 1'b0;
        repeat (6) step();
        checks++;
        if (hs.size() != 3 || hs[0] != 0 || hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d handshakes at %0d,%0d,%0d, want 3 at 0,4,8",
                     hs.size(), hs[0], hs[1], hs[2]);
        end
        $display("back_to_back: %0d AR handshakes, spacing %0d", hs.size(), hs[1] - hs[0]);
    endtask

    task automatic test_latency();
        int rv1, rv2, beats, men;
        logic [31:0] d[2];
        logic        l[2];
        rv1 = -1; rv2 = -1; beats = 0; men = 0;
        araddr = 32'h8000_0300; arid = 4'd4; arlen = 8'd1; arsize = 3'd2; arburst = AXI4_BURST_INCR;
        rready = 1'b1;
        arvalid_lat = 1'b1;
        step();
        arvalid_lat = 1'b0;
        for (int n = 0; n < 30 && beats < 2; n++) begin
            if (mem_en_lat) men++;
            if (rvalid_lat) begin
                if (beats == 0) rv1 = n; else rv2 = n;
                d[beats] = rdata_lat;
                l[beats] = rlast_lat;
                beats++;
            end
            step();
        end
        // First beat: 4 DELAY cycles + FETCH + LOAD -> sample index 6.
        checks++;
        if (rv1 != 6 || rv2 != 9) begin
            errors++;
            $display("FAIL lat_timing: got rvalid at %0d and %0d, want 6 and 9", rv1, rv2);
        end
        checks++;
        if (beats != 2 || men != 2 || {d[0], l[0], d[1], l[1]} !== {32'hDA5A_595A, 1'b0, 32'hDA5A_595E, 1'b1}) begin
            errors++;
            $display("FAIL lat_beats: got beats=%0d reads=%0d d0=%h l0=%b d1=%h l1=%b, want 2 2 da5a595a 0 da5a595e 1",
                     beats, men, d[0], l[0], d[1], l[1]);
        end
        $display("latency4: first rvalid at %0d, second at %0d", rv1, rv2);
    endtask

    task automatic test_addr_window();
        bit err;
`ifdef IFU_SRAM_RSP_ADDR_CHECK_EN
        err = 1'b1;
`else
        err = 1'b0;
`endif
        issue_ar(32'h0000_1000, 4'd2, 8'd1, 3'd2, AXI4_BURST_INCR);
        collect(20);
        checks++;
        if (timed_out || obs_rdata.size() != 2 || obs_maddr.size() != (err ? 0 : 2)) begin
            errors++;
            $display("FAIL win_count: got beats=%0d mem_reads=%0d timeout=%b, want 2 %0d 0",
                     obs_rdata.size(), obs_maddr.size(), timed_out, err ? 0 : 2);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs_rdata[i], obs_rresp[i], obs_rlast[i]} !==
                {err ? 32'h0 : mem_word(32'h0000_1000 + 32'(4 * i)),
                 err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY, (i == 1)}) begin
                errors++;
                $display("FAIL win_beat%0d: got rdata=%h rresp=%b rlast=%b, want %h %b %b", i,
                         obs_rdata[i], obs_rresp[i], obs_rlast[i],
                         err ? 32'h0 : mem_word(32'h0000_1000 + 32'(4 * i)),
                         err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY, (i == 1));
            end
        end
        $display("addr_window: addr=00001000 rresp=%b,%b", obs_rresp[0], obs_rresp[1]);
    endtask

    task automatic test_reset_mid();
        int hs, n, rv_seen;
        rready = 1'b1;
        issue_ar(32'h8000_0400, 4'd7, 8'd7, 3'd2, AXI4_BURST_INCR);
        hs = 0; n = 0;
        while (hs < 1 && n < 20) begin
            if (rvalid && rready) hs++;
            step();
            n++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({hs[0], rvalid, arready, rlast, mem_en, rid, rresp} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00} ||
            rdata !== 32'd0) begin
            errors++;
            $display("FAIL midreset_now: got hs=%0d rvalid=%b arready=%b rlast=%b mem_en=%b rid=%h rresp=%b rdata=%h, want 1 0 1 0 0 0 00 0",
                     hs, rvalid, arready, rlast, mem_en, rid, rresp, rdata);
        end
        step(); step();
        reset = 1'b1;
        rv_seen = 0;
        repeat (8) begin
            if (rvalid || mem_en) rv_seen++;
            step();
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles after reset, want 0", rv_seen);
        end
        issue_ar(32'h8000_0500, 4'd2, 8'd0, 3'd2, AXI4_BURST_INCR);
        collect(20);
        checks++;
        if (timed_out || obs_rdata.size() != 1 || first_rv != 2 ||
            {obs_rdata[0], obs_rid[0], obs_rlast[0]} !== {32'hDA5A_5F5A, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL midreset_after: got beats=%0d rv_at=%0d rdata=%h rid=%h rlast=%b, want 1 2 da5a5f5a 2 1",
                     obs_rdata.size(), first_rv, obs_rdata[0], obs_rid[0], obs_rlast[0]);
        end
        $display("reset_mid: abandoned burst, new request rdata=%h", obs_rdata[0]);
    endtask

    initial begin
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; arvalid_lat = 1'b0; rready = 1'b1;
        test_reset();
        test_single();
        test_burst_modes();
        test_len255();
        test_backpressure();
        test_back_to_back();
        test_latency();
        test_addr_window();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
